pce_rom_loader: RTL and testbench

// - Accepts the HPS cartridge download stream (16-bit words) and converts it into toggle-handshake
//   ROM writes for the DDR3 and SDRAM ROM stores; both stores are written in parallel.
// - Applies optional per-byte bit reversal ("ROM Data Swap").
// - Derives cart metadata consumed by pce_top: SGX flag, Populous mapper detect, 512-byte header flag, size.
// - Sits between hps_io and the ddram/sdram controllers; back-pressures hps_io via ioctl_wait.

---
 rtl/pce_pkg.sv | 36 +++
 rtl/pce_rom_loader.sv | 143 ++++++++++++++
 tb/tb_pce_rom_loader.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pce_pkg.sv
// Shared types and constants for the PC Engine cartridge loader.
// Holds the Populous signature table and the byte bit-reversal helper.
package pce_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        ACK
    } loader_state_t;

    typedef struct packed {
        logic [3:0]  ofs;
        logic [15:0] val;
    } pop_sig_t;

    localparam int POP_SIG_N = 4;

    localparam pop_sig_t POP_SIG [POP_SIG_N] = '{
        '{ofs: 4'd6,  val: 16'h4F50},
        '{ofs: 4'd8,  val: 16'h5550},
        '{ofs: 4'd10, val: 16'h4F4C},
        '{ofs: 4'd12, val: 16'h5355}
    };

    localparam logic [19:0] POP_BASE0 = 20'h1F2;
    localparam logic [19:0] POP_BASE1 = 20'h212;

    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/pce_rom_loader.sv
// Turns the HPS download word stream into toggle-handshake ROM writes
// for the DDR3 and SDRAM stores, and derives cart metadata on the way.
module pce_rom_loader
    import pce_pkg::*;
#(
    parameter logic [4:0] SGX_INDEX = 5'd2,
    parameter int         ADDR_W    = 24
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              cart_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [15:0]       ioctl_dout,
    input  logic              swap_en,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] romwr_a,
    output logic [15:0]       romwr_d,
    output logic              rom_wr,
    input  logic              dd_wrack,
    input  logic              sd_wrack,
    output logic              sgx,
    output logic [1:0]        populous,
    output logic              hdr_ofs,
    output logic [7:0]        rom_sz,
    output logic              load_done,
    output logic              proto_err
);

    loader_state_t state;
    loader_state_t state_d;

    logic              dl_q;
    logic              dl_rise;
    logic              dl_fall;
    logic              acks_eq;
    logic              pop_win;
    logic              pop_bad;
    logic              wait_d;
    logic [ADDR_W-1:0] addr_d;
    logic              rom_wr_d;
    logic [1:0]        pop_d;
    logic              sgx_d;
    logic              perr_d;

    assign dl_rise = cart_download & ~dl_q;
    assign dl_fall = ~cart_download & dl_q;
    assign acks_eq = (rom_wr == dd_wrack) && (rom_wr == sd_wrack);

    assign hdr_ofs = romwr_a[9];
    assign rom_sz  = romwr_a[23:16];

    always_comb begin
        romwr_d = ioctl_dout;
        if (swap_en) begin
            romwr_d = {bitrev8(ioctl_dout[15:8]),
                       bitrev8(ioctl_dout[7:0])};
        end
    end

    // Signature words live at the same low offsets in both windows.
    always_comb begin
        pop_win = (romwr_a[23:4] == POP_BASE0) ||
                  (romwr_a[23:4] == POP_BASE1);
        pop_bad = 1'b0;
        for (int i = 0; i < POP_SIG_N; i++) begin
            if (romwr_a[3:0] == POP_SIG[i].ofs &&
                romwr_d != POP_SIG[i].val) begin
                pop_bad = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state;
        wait_d   = ioctl_wait;
        addr_d   = romwr_a;
        rom_wr_d = rom_wr;
        pop_d    = populous;
        sgx_d    = sgx;
        perr_d   = proto_err;
        if (dl_rise) begin
            state_d = RECV;
            wait_d  = 1'b0;
            addr_d  = '0;
            pop_d   = 2'b11;
            sgx_d   = (ioctl_index[4:0] == SGX_INDEX);
            perr_d  = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                end
                RECV: begin
                    if (!cart_download) begin
                        state_d = IDLE;
                    end else if (ioctl_wr) begin
                        rom_wr_d = ~rom_wr;
                        wait_d   = 1'b1;
                        state_d  = ACK;
                        if (pop_win && pop_bad) begin
                            pop_d[romwr_a[13]] = 1'b0;
                        end
                    end
                end
                ACK: begin
                    if (ioctl_wr) begin
                        perr_d = 1'b1;
                    end
                    // A dropped download still finishes its last word.
                    if (acks_eq) begin
                        wait_d  = 1'b0;
                        addr_d  = romwr_a + ADDR_W'(2);
                        state_d = cart_download ? RECV : IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // rom_wr and the metadata hold across reset to keep ack parity.
    always_ff @(posedge clk_sys) begin
        dl_q <= cart_download;
        if (reset) begin
            state      <= IDLE;
            ioctl_wait <= 1'b0;
            load_done  <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            state      <= state_d;
            ioctl_wait <= wait_d;
            load_done  <= dl_fall;
            proto_err  <= perr_d;
            romwr_a    <= addr_d;
            rom_wr     <= rom_wr_d;
            populous   <= pop_d;
            sgx        <= sgx_d;
        end
    end

endmodule

// File: tb/tb_pce_rom_loader.sv
// Directed bench for pce_rom_loader with a delayed-ack store model.
// Covers handshake timing, swap, metadata, populous and protocol errors.
module tb_pce_rom_loader;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        cart_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [15:0] ioctl_dout;
    logic        swap_en;
    logic        ioctl_wait;
    logic [23:0] romwr_a;
    logic [15:0] romwr_d;
    logic        rom_wr;
    logic        dd_wrack = 1'b0;
    logic        sd_wrack = 1'b0;
    logic        sgx;
    logic [1:0]  populous;
    logic        hdr_ofs;
    logic [7:0]  rom_sz;
    logic        load_done;
    logic        proto_err;

    int nchk = 0;
    int nerr = 0;
    int ack_dly = 3;
    int acnt = 0;
    logic ack_hold = 1'b0;
    int tog = 0;
    int ldc = 0;
    logic rw_prev = 1'b0;

    pce_rom_loader dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .cart_download (cart_download),
        .ioctl_index   (ioctl_index),
        .ioctl_wr      (ioctl_wr),
        .ioctl_dout    (ioctl_dout),
        .swap_en       (swap_en),
        .ioctl_wait    (ioctl_wait),
        .romwr_a       (romwr_a),
        .romwr_d       (romwr_d),
        .rom_wr        (rom_wr),
        .dd_wrack      (dd_wrack),
        .sd_wrack      (sd_wrack),
        .sgx           (sgx),
        .populous      (populous),
        .hdr_ofs       (hdr_ofs),
        .rom_sz        (rom_sz),
        .load_done     (load_done),
        .proto_err     (proto_err)
    );

    always #5 clk_sys = ~clk_sys;

    // Both stores acknowledge ack_dly cycles after each toggle.
    always @(posedge clk_sys) begin
        if (!ack_hold && (rom_wr != dd_wrack)) begin
            if (acnt >= ack_dly - 1) begin
                dd_wrack <= rom_wr;
                sd_wrack <= rom_wr;
                acnt     <= 0;
            end else begin
                acnt <= acnt + 1;
            end
        end
    end

    always @(negedge clk_sys) begin
        if (rom_wr != rw_prev) tog++;
        rw_prev = rom_wr;
        if (load_done) ldc++;
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic wait_release(output int wc);
        wc = 0;
        while (ioctl_wait && wc < 64) begin
            wc++;
            @(negedge clk_sys);
        end
        if (wc >= 64) chk("ack_timeout", 32'(wc), 32'd0);
    endtask

    task automatic send_word(input logic [15:0] d, output int wc);
        @(negedge clk_sys);
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        wait_release(wc);
    endtask

    task automatic start_dl(input logic [7:0] idx);
        @(negedge clk_sys);
        ioctl_index   = idx;
        cart_download = 1'b1;
        @(negedge clk_sys);
    endtask

    function automatic logic [15:0] pop_data(input int a);
        case (a)
            'h1F26:  return 16'h4F50;
            'h1F28:  return 16'h5550;
            'h1F2A:  return 16'h4F4C;
            'h1F2C:  return 16'h5355;
            'h2126:  return 16'h4F50;
            default: return 16'h0000;
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc;
        int t0;
        int l0;
        logic rw;
        reset         = 1'b1;
        cart_download = 1'b0;
        ioctl_index   = 8'h00;
        ioctl_wr      = 1'b0;
        ioctl_dout    = 16'h0000;
        swap_en       = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("rst_wait", 32'(ioctl_wait), 32'd0);
        chk("rst_ldone", 32'(load_done), 32'd0);
        chk("rst_perr", 32'(proto_err), 32'd0);
        reset = 1'b0;
        @(negedge clk_sys);

        // Four words, acks three cycles late.
        ack_dly = 3;
        start_dl(8'h02);
        chk("t1_sgx", 32'(sgx), 32'd1);
        chk("t1_pop", 32'(populous), 32'd3);
        #1;
        t0 = tog;
        l0 = ldc;
        for (int i = 0; i < 3; i++) begin
            chk("t1_addr", 32'(romwr_a), 32'(i * 2));
            send_word(16'h1000 + 16'(i), wc);
            chk("t1_wait_cyc", 32'(wc), 32'd4);
        end
        chk("t1_addr3", 32'(romwr_a), 32'd6);
        @(negedge clk_sys);
        ioctl_dout = 16'h1003;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        ioctl_wr      = 1'b0;
        cart_download = 1'b0;
        wait_release(wc);
        chk("t1_final_addr", 32'(romwr_a), 32'd8);
        #1;
        chk("t1_toggles", 32'(tog - t0), 32'd4);
        send_word(16'hBEEF, wc);
        #1;
        chk("t1_idle_addr", 32'(romwr_a), 32'd8);
        chk("t1_idle_tog", 32'(tog - t0), 32'd4);
        chk("t1_ldone", 32'(ldc - l0), 32'd1);

        // SuperGrafx detection uses only the low 5 index bits.
        start_dl(8'h01);
        chk("sgx_idx01", 32'(sgx), 32'd0);
        cart_download = 1'b0;
        @(negedge clk_sys);
        start_dl(8'h22);
        chk("sgx_idx22", 32'(sgx), 32'd1);
        cart_download = 1'b0;
        @(negedge clk_sys);

        swap_en    = 1'b1;
        ioctl_dout = 16'h0180;
        #1 chk("swap_0180", 32'(romwr_d), 32'h8001);
        ioctl_dout = 16'h1234;
        #1 chk("swap_1234", 32'(romwr_d), 32'h482C);
        swap_en = 1'b0;
        #1 chk("noswap_1234", 32'(romwr_d), 32'h1234);

        // Populous signature in window 0, mismatch in window 1.
        ack_dly = 1;
        start_dl(8'h01);
        chk("pop_start", 32'(populous), 32'd3);
        #1;
        l0 = ldc;
        for (int a = 0; a <= 'h2128; a += 2) begin
            if (a == 'h200) begin
                chk("hdr_ofs_200", 32'(hdr_ofs), 32'd1);
                chk("rom_sz_200", 32'(rom_sz), 32'd0);
            end
            send_word(pop_data(a), wc);
            if (a == 0) chk("min_wait_cyc", 32'(wc), 32'd2);
            if (a == 'h1F2C) chk("pop_win0", 32'(populous), 32'd3);
        end
        chk("pop_final", 32'(populous), 32'd1);
        chk("pop_addr", 32'(romwr_a), 32'h212A);
        chk("pop_hdr", 32'(hdr_ofs), 32'd0);
        chk("pop_sz", 32'(rom_sz), 32'd0);
        chk("pop_perr", 32'(proto_err), 32'd0);
        cart_download = 1'b0;
        repeat (3) @(negedge clk_sys);
        #1 chk("pop_ldone", 32'(ldc - l0), 32'd1);

        // Write during ACK, then reset while the ack is outstanding.
        ack_hold = 1'b1;
        start_dl(8'h01);
        @(negedge clk_sys);
        ioctl_dout = 16'h5A5A;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        rw       = rom_wr;
        chk("pe_wait", 32'(ioctl_wait), 32'd1);
        ioctl_wr = 1'b1;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
        chk("pe_flag", 32'(proto_err), 32'd1);
        chk("pe_no_tog", 32'(rom_wr), 32'(rw));
        chk("pe_addr", 32'(romwr_a), 32'd0);
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        chk("rst_ack_wait", 32'(ioctl_wait), 32'd0);
        chk("rst_ack_rw", 32'(rom_wr), 32'(rw));
        chk("rst_ack_perr", 32'(proto_err), 32'd0);
        ack_hold      = 1'b0;
        cart_download = 1'b0;
        repeat (2) @(negedge clk_sys);
        start_dl(8'h01);
        send_word(16'h1111, wc);
        chk("restart_addr", 32'(romwr_a), 32'd2);
        chk("restart_wait", 32'(ioctl_wait), 32'd0);
        chk("restart_perr", 32'(proto_err), 32'd0);
        cart_download = 1'b0;
        repeat (2) @(negedge clk_sys);

        $display("Simulation finished: %0d checks, %0d errors",
                 nchk, nerr);
        $finish;
    end

endmodule
